// File: rtl/audio_link_pkg.sv
// Shared 8b10b link definitions: K-character codes, framer state encoding, symbol struct.
// Latency: n/a (constants and types only).
// Backpressure: n/a. Imported by the frame packer and by the downstream frame unpacker.
package audio_link_pkg;

    // K-characters; every other byte on the link goes out with the K flag clear.
    localparam logic [7:0] IDLE_K = 8'hBC;   // K28.5, comma-bearing filler between frames
    localparam logic [7:0] SOF_K  = 8'hFB;   // K27.7
    localparam logic [7:0] EOF_K  = 8'hFD;   // K29.7

    // The state names the byte being emitted in the current cycle.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_SEQ,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CSUM,
        ST_EOF
    } frameState_t;

    // One link symbol: K flag plus byte, as presented to the encoder.
    typedef struct packed {
        logic       control;
        logic [7:0] data;
    } linkSym_t;

endpackage

// File: rtl/audio_frame_packer_sample_fifo.sv
// Synchronous sample FIFO with occupancy count; exposes the head and the entry behind it.
// Latency: a pushed word is visible at head one cycle after the push edge when the FIFO was empty.
// Backpressure: pushes are ignored while full, pops are ignored while empty; nothing is overwritten.
// Ports: clk/reset (async active-low), push/pushData, pop, head, nextHead, count, full, empty.
module sample_fifo #(
    parameter int DEPTH = 8,    // power of two, >= 2
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         nextHead,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign head     = mem[rdPtr];
    // Second entry lets the reader look past a word it is popping this cycle.
    assign nextHead = mem[rdPtr + PTR_W'(1)];

    // Storage carries no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/audio_frame_packer.sv
// Packs 16-bit audio samples into SOF/seq/samples/checksum/EOF frames with K28.5 idle fill.
// Latency: registered outputs, one byte per clock; SOF follows the idle cycle that sees a full frame buffered.
// Backpressure: in_ready drops only when the sample FIFO is full; the output side never stalls.
// Ports: clk, reset (async active-low), in_sample/in_valid/in_ready, outControl (K flag), outData,
//        frame_active (high for SOF..EOF bytes).
module audio_frame_packer
    import audio_link_pkg::*;
#(
    parameter int SAMPLES_PER_FRAME = 4,
    parameter int FIFO_DEPTH        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_sample,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        outControl,
    output logic [7:0]  outData,
    output logic        frame_active
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SC_W  = $clog2(SAMPLES_PER_FRAME + 1);

    frameState_t       state;
    frameState_t       nextState;
    linkSym_t          nextSym;
    logic [7:0]        seq;
    logic [7:0]        checksum;
    logic [SC_W-1:0]   sampleCnt;
    logic [7:0]        curLow;
    logic              readyEn;
    logic              lastSample;

    logic              fifoPush;
    logic              fifoPop;
    logic [15:0]       fifoHead;
    logic [15:0]       fifoNextHead;
    logic [15:0]       upcoming;
    logic [CNT_W-1:0]  fifoCount;
    logic              fifoFull;
    logic              fifoEmpty;

    // readyEn holds in_ready low through reset and comes up on the first edge after release.
    assign in_ready   = readyEn && !fifoFull;
    assign fifoPush   = in_valid && in_ready;
    assign fifoPop    = (state == ST_DATA_LO) && !fifoEmpty;
    assign lastSample = (sampleCnt == SC_W'(SAMPLES_PER_FRAME - 1));

    // Leaving DATA_LO pops the head on the same edge, so the next high byte
    // must come from the entry behind it.
    assign upcoming   = (state == ST_DATA_LO) ? fifoNextHead : fifoHead;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_sample_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifoPush),
        .pushData (in_sample),
        .pop      (fifoPop),
        .head     (fifoHead),
        .nextHead (fifoNextHead),
        .count    (fifoCount),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    always_comb begin
        nextState = state;
        nextSym   = '{control: 1'b1, data: IDLE_K};

        case (state)
            ST_IDLE: begin
                // Only start once the whole frame is buffered: no underrun mid-frame.
                if (fifoCount >= CNT_W'(SAMPLES_PER_FRAME)) begin
                    nextState = ST_SOF;
                end
            end
            ST_SOF:     nextState = ST_SEQ;
            ST_SEQ:     nextState = ST_DATA_HI;
            ST_DATA_HI: nextState = ST_DATA_LO;
            ST_DATA_LO: nextState = lastSample ? ST_CSUM : ST_DATA_HI;
            ST_CSUM:    nextState = ST_EOF;
            ST_EOF:     nextState = ST_IDLE;
            default:    nextState = ST_IDLE;
        endcase

        // Outputs are registered, so the symbol is chosen for the state being entered.
        case (nextState)
            ST_IDLE:    nextSym = '{control: 1'b1, data: IDLE_K};
            ST_SOF:     nextSym = '{control: 1'b1, data: SOF_K};
            ST_SEQ:     nextSym = '{control: 1'b0, data: seq};
            ST_DATA_HI: nextSym = '{control: 1'b0, data: upcoming[15:8]};
            ST_DATA_LO: nextSym = '{control: 1'b0, data: curLow};
            // checksum lacks the low byte on the wire right now; fold it in here.
            ST_CSUM:    nextSym = '{control: 1'b0, data: checksum ^ outData};
            ST_EOF:     nextSym = '{control: 1'b1, data: EOF_K};
            default:    nextSym = '{control: 1'b1, data: IDLE_K};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            outControl   <= 1'b1;
            outData      <= IDLE_K;
            frame_active <= 1'b0;
            seq          <= 8'd0;
            checksum     <= 8'd0;
            sampleCnt    <= '0;
            curLow       <= 8'd0;
            readyEn      <= 1'b0;
        end else begin
            readyEn      <= 1'b1;
            state        <= nextState;
            outControl   <= nextSym.control;
            outData      <= nextSym.data;
            frame_active <= (nextState != ST_IDLE);

            // Capture the low byte with its high byte so DATA_LO is independent of the pop.
            if (nextState == ST_DATA_HI) begin
                curLow <= upcoming[7:0];
            end

            // checksum accumulates whatever non-K byte is on the wire this cycle.
            case (state)
                ST_SOF: begin
                    checksum  <= 8'd0;
                    sampleCnt <= '0;
                end
                ST_SEQ, ST_DATA_HI: begin
                    checksum <= checksum ^ outData;
                end
                ST_DATA_LO: begin
                    checksum  <= checksum ^ outData;
                    sampleCnt <= sampleCnt + SC_W'(1);
                end
                ST_EOF: begin
                    seq <= seq + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
